adc_phase_tuner: RTL and testbench

Automatic sampling-phase calibration controller for the AD9980 analog video front end. It sweeps the 5-bit ADC clock phase across all 32 settings. For each setting it re-runs the I2C register initialiser, waits for the picture to settle, and measures a one-frame sharpness metric. At the end it reprograms the phase that gave the highest metric and reports lock. It sits directly upstream of the I2C init stage: it drives that stage's `Phase` input and reset, and consumes its `Done`.

---
 rtl/adc_phase_tuner.sv | 163 ++++++++++++++++
 tb/tb_adc_phase_tuner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_phase_tuner.sv
// adc_phase_tuner: sweeps the ADC sampling phase 0..31, re-runs the I2C init
// for each setting, scores one frame of adjacent-pixel differences, then
// reprograms the best-scoring phase and reports lock.
module adc_phase_tuner #(
   parameter int          SETTLE_FRAMES = 2,
   parameter int          ACC_W         = 32,
   parameter logic [23:0] INIT_TIMEOUT  = 24'd16000000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Vsync,
   input  logic             PixValid,
   input  logic [7:0]       Pix,
   input  logic             InitDone,
   input  logic             Retune,
   output logic [4:0]       Phase,
   output logic             InitReset,
   output logic             Locked,
   output logic [4:0]       BestPhase,
   output logic [ACC_W-1:0] BestMetric
);

   typedef enum logic [3:0] {
      APPLY, GUARD, WAIT_INIT, SETTLE, MEASURE, COMPARE, NEXT,
      FINAL_APPLY, FINAL_GUARD, FINAL_WAIT, LOCKED
   } state_t;

   state_t           state;
   logic             vsync_q;
   logic             prev_valid;
   logic [7:0]       prev_pix;
   logic [ACC_W-1:0] acc;
   logic [7:0]       frame_cnt;
   logic [23:0]      timer;

   logic             vs_edge;
   logic             timer_expired;
   logic [7:0]       pix_diff;
   logic [ACC_W:0]   acc_sum;

   // Edge detect, init timeout, and the saturating |Pix - prevPix| sum.
   always_comb begin
      vs_edge       = Vsync & ~vsync_q;
      timer_expired = ({1'b0, timer} + 25'd1) >= {1'b0, INIT_TIMEOUT};
      pix_diff      = (Pix >= prev_pix) ? (Pix - prev_pix) : (prev_pix - Pix);
      acc_sum       = {1'b0, acc} + {{(ACC_W-7){1'b0}}, pix_diff};
   end

   // Previous-cycle history: Vsync level, pixel-chain valid and last valid pixel.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vsync_q    <= 1'b0;
         prev_valid <= 1'b0;
         prev_pix   <= 8'd0;
      end else begin
         vsync_q    <= Vsync;
         prev_valid <= PixValid;
         if (PixValid) prev_pix <= Pix;
      end
   end

   // Sweep controller. InitReset is registered, so it is high in the cycle
   // after APPLY/FINAL_APPLY; Phase has then been stable for a full cycle and
   // the init stage's Done is already cleared when WAIT_INIT starts sampling.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= APPLY;
         Phase      <= 5'd0;
         BestPhase  <= 5'd0;
         BestMetric <= '0;
         acc        <= '0;
         InitReset  <= 1'b0;
         Locked     <= 1'b0;
         frame_cnt  <= 8'd0;
         timer      <= 24'd0;
      end else begin
         InitReset <= 1'b0;
         case (state)
            APPLY: begin
               InitReset <= 1'b1;
               state     <= GUARD;
            end
            GUARD: begin
               timer <= 24'd0;
               state <= WAIT_INIT;
            end
            WAIT_INIT: begin
               if (InitDone) begin
                  frame_cnt <= 8'd0;
                  state     <= SETTLE;
               end else if (timer_expired) begin
                  acc   <= '0;        // abandoned step scores zero
                  state <= COMPARE;
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            SETTLE: begin
               if (vs_edge) begin
                  if (frame_cnt + 8'd1 >= 8'(SETTLE_FRAMES)) begin
                     acc   <= '0;     // this edge opens the measured frame
                     state <= MEASURE;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            MEASURE: begin
               if (vs_edge) begin
                  state <= COMPARE;   // closing edge truncates any live burst
               end else if (PixValid && prev_valid) begin
                  acc <= acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
               end
            end
            COMPARE: begin
               if (acc > BestMetric) begin
                  BestMetric <= acc;
                  BestPhase  <= Phase;
               end
               state <= NEXT;
            end
            NEXT: begin
               if (Phase == 5'd31) begin
                  Phase <= BestPhase; // settle the phase before the final pulse
                  state <= FINAL_APPLY;
               end else begin
                  Phase <= Phase + 5'd1;
                  state <= APPLY;
               end
            end
            FINAL_APPLY: begin
               Phase     <= BestPhase;
               InitReset <= 1'b1;
               state     <= FINAL_GUARD;
            end
            FINAL_GUARD: begin
               timer <= 24'd0;
               state <= FINAL_WAIT;
            end
            FINAL_WAIT: begin
               if (InitDone || timer_expired) begin
                  Locked <= 1'b1;
                  state  <= LOCKED;
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            LOCKED: begin
               if (Retune) begin
                  Locked     <= 1'b0;
                  Phase      <= 5'd0;
                  BestPhase  <= 5'd0;
                  BestMetric <= '0;
                  acc        <= '0;
                  state      <= APPLY;
               end
            end
            default: state <= APPLY;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_phase_tuner.sv
// tb_adc_phase_tuner: closed-loop bench with an I2C-init model, a phase-dependent
// video source and an arithmetic reference for the winning phase and metric.
module tb_adc_phase_tuner;

   localparam int ACC_W   = 11;               // small so saturation is reachable
   localparam int MAXM    = (1 << ACC_W) - 1;
   localparam int FRAME   = 48;
   localparam int INIT_DLY = 20;

   logic             Clk, Reset, Vsync, PixValid, InitDone, Retune;
   logic [7:0]       Pix;
   logic [4:0]       Phase, BestPhase;
   logic             InitReset, Locked;
   logic [ACC_W-1:0] BestMetric;

   logic [7:0] pix_tab [32][4][4];
   int         stuck_ph;
   int         pulse_q[$];
   int         frame_no;
   int         total, bad;

   adc_phase_tuner #(.SETTLE_FRAMES(2), .ACC_W(ACC_W), .INIT_TIMEOUT(24'd300)) dut (
      .Clk(Clk), .Reset(Reset), .Vsync(Vsync), .PixValid(PixValid), .Pix(Pix),
      .InitDone(InitDone), .Retune(Retune), .Phase(Phase), .InitReset(InitReset),
      .Locked(Locked), .BestPhase(BestPhase), .BestMetric(BestMetric));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Video: Vsync high 2 cycles per frame, 4 lines of 4 pixels from pix_tab[Phase].
   initial begin
      int t;
      t = FRAME - 1; frame_no = 0;
      Vsync = 1'b0; PixValid = 1'b0; Pix = 8'd0;
      forever begin
         @(negedge Clk);
         t = (t == FRAME - 1) ? 0 : t + 1;
         Vsync = (t < 2);
         if (t == 0) frame_no++;
         if (t >= 4 && ((t - 4) % 10) < 4 && ((t - 4) / 10) < 4) begin
            PixValid = 1'b1;
            Pix = pix_tab[Phase][(t - 4) / 10][(t - 4) % 10];
         end else begin
            PixValid = 1'b0;
            Pix = 8'($urandom);                 // junk that must be ignored
         end
      end
   end

   // I2C init model: Done INIT_DLY cycles after each InitReset, never at stuck_ph.
   initial begin
      int cnt;
      cnt = 0; InitDone = 1'b0;
      forever begin
         @(negedge Clk);
         if (InitReset) begin
            pulse_q.push_back(int'(Phase));
            cnt = INIT_DLY; InitDone = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && int'(Phase) != stuck_ph) InitDone = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Reference: score = sum of |adjacent diffs| within each line, capped; stuck phase scores 0.
   function automatic int metric_of(input int ph);
      int s, a;
      if (ph == stuck_ph) return 0;
      s = 0;
      for (int l = 0; l < 4; l++)
         for (int p = 1; p < 4; p++) begin
            a = int'(pix_tab[ph][l][p]) - int'(pix_tab[ph][l][p-1]);
            s += (a < 0) ? -a : a;
         end
      return (s > MAXM) ? MAXM : s;
   endfunction

   task automatic model_best(output int bp, output int bm);
      bp = 0; bm = 0;
      for (int ph = 0; ph < 32; ph++)
         if (metric_of(ph) > bm) begin bm = metric_of(ph); bp = ph; end
   endtask

   task automatic cyc();
      @(posedge Clk); #1;
   endtask

   task automatic do_reset();
      cyc(); Reset = 1'b1;
      cyc(); Reset = 1'b0;
      pulse_q.delete();
   endtask

   task automatic check_sweep(input string tag, input int exp_ph, input int exp_m);
      bit ok;
      int errs;
      ok = 0;
      for (int i = 0; i < 20000; i++) begin
         cyc();
         if (Locked) begin ok = 1; break; end
      end
      chk({tag, ".locked"}, ok, 1);
      chk({tag, ".best_phase"}, BestPhase, exp_ph);
      chk({tag, ".best_metric"}, BestMetric, exp_m);
      chk({tag, ".phase"}, Phase, exp_ph);
      chk({tag, ".pulses"}, pulse_q.size(), 33);
      errs = 0;
      for (int i = 0; i < pulse_q.size() && i < 33; i++)
         if (pulse_q[i] != ((i < 32) ? i : exp_ph)) errs++;
      chk({tag, ".pulse_phase_errs"}, errs, 0);
   endtask

   task automatic fill_random();
      for (int ph = 0; ph < 32; ph++)
         for (int l = 0; l < 4; l++)
            for (int p = 0; p < 4; p++) pix_tab[ph][l][p] = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_phase(input int ph, input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 15000; i++) begin
         cyc();
         if (int'(Phase) == ph) begin ok = 1; break; end
      end
      chk({tag, ".reach_phase"}, ok, 1);
   endtask

   typedef struct {
      int peak_ph; int peak_d; int base_d; int stuck; int exp_ph; int exp_m;
   } vec_t;

   initial begin
      vec_t vecs [4];
      int   bp, bm, f0;
      bit   ok;
      total = 0; bad = 0; stuck_ph = -1;
      Reset = 1'b1; Retune = 1'b0;
      vecs[0] = '{13,  40, 5, -1, 13, 480};   // single peak
      vecs[1] = '{ 0,   5, 5, -1,  0,  60};   // flat: ties keep phase 0
      vecs[2] = '{ 7, 100, 5,  7,  0,  60};   // best phase times out, scored 0
      vecs[3] = '{31, 200, 5, -1, 31, MAXM};  // last phase, saturated (2400)
      fill_random();
      repeat (3) cyc();
      chk("rst.phase", Phase, 0);
      chk("rst.best_phase", BestPhase, 0);
      chk("rst.best_metric", BestMetric, 0);
      chk("rst.locked", Locked, 0);
      chk("rst.init_reset", InitReset, 0);
      Reset = 1'b0;

      // Table-driven sweeps
      for (int v = 0; v < 4; v++) begin
         for (int ph = 0; ph < 32; ph++)
            for (int l = 0; l < 4; l++)
               for (int p = 0; p < 4; p++)
                  pix_tab[ph][l][p] = (p % 2 == 1) ?
                     8'((ph == vecs[v].peak_ph) ? vecs[v].peak_d : vecs[v].base_d) : 8'd0;
         stuck_ph = vecs[v].stuck;
         do_reset();
         check_sweep($sformatf("vec%0d", v), vecs[v].exp_ph, vecs[v].exp_m);
      end

      // Random video against the reference model
      for (int r = 0; r < 2; r++) begin
         fill_random();
         stuck_ph = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
         model_best(bp, bm);
         do_reset();
         check_sweep($sformatf("rnd%0d", r), bp, bm);
      end

      // Reset during the measured frame at phase 20
      fill_random(); stuck_ph = -1;
      model_best(bp, bm);
      do_reset();
      wait_phase(20, "midrst");
      ok = 0;
      for (int i = 0; i < 500; i++) begin cyc(); if (InitDone) begin ok = 1; break; end end
      chk("midrst.init_done", ok, 1);
      f0 = frame_no; ok = 0;
      for (int i = 0; i < 500; i++) begin cyc(); if (frame_no >= f0 + 2) begin ok = 1; break; end end
      chk("midrst.frames", ok, 1);
      repeat (10) cyc();
      Reset = 1'b1;
      cyc();
      chk("midrst.phase", Phase, 0);
      chk("midrst.best_phase", BestPhase, 0);
      chk("midrst.best_metric", BestMetric, 0);
      chk("midrst.locked", Locked, 0);
      chk("midrst.init_reset", InitReset, 0);
      Reset = 1'b0;
      pulse_q.delete();
      ok = 0;
      for (int i = 0; i < 10; i++) begin cyc(); if (pulse_q.size() > 0) begin ok = 1; break; end end
      chk("midrst.first_pulse_seen", ok, 1);
      if (ok) chk("midrst.first_pulse_phase", pulse_q[0], 0);
      check_sweep("midrst", bp, bm);

      // Retune from LOCKED, then a second Retune mid-sweep that must be ignored
      fill_random(); stuck_ph = -1;
      model_best(bp, bm);
      Retune = 1'b1;
      pulse_q.delete();
      cyc();
      Retune = 1'b0;
      chk("retune.locked", Locked, 0);
      chk("retune.phase", Phase, 0);
      chk("retune.best_phase", BestPhase, 0);
      chk("retune.best_metric", BestMetric, 0);
      wait_phase(5, "retune2");
      Retune = 1'b1;
      cyc();
      Retune = 1'b0;
      chk("retune2.locked", Locked, 0);
      chk("retune2.phase", Phase, 5);
      check_sweep("retune2", bp, bm);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
